// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word-aligned ROM read per
// cycle, queues returned words with their PC in a small in-order buffer and
// hands them to decode over valid/ready. A redirect flushes the buffer and
// squashes any in-flight read, then restarts fetch at the target.
// DEPTH may be 2..4.
module instr_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_valid,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_rdata_vld,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_instr_vld,
   input  logic        i_id_ready
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic          inflight;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   entry_pc    [DEPTH];
   logic [31:0]   entry_instr [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic [OW-1:0] occupancy;
   logic [31:0]   redirect_target;
   logic          unused_redirect_bits;

   // Circular pointer advance; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
   assign unused_redirect_bits = ^i_redirect_pc[1:0];

   // Handshake decisions. Occupancy counts buffered words plus the word still
   // owed by the ROM, so a request is only made when its reply has a slot.
   always_comb begin
      pop       = (count != '0) & i_id_ready & ~i_redirect;
      push      = i_rdata_vld & inflight & ~i_redirect;
      occupancy = OW'(count) + OW'(inflight) - OW'(pop);
      issue     = rst_n & i_mem_ready & ~i_redirect & (occupancy < OW'(DEPTH));
   end

   // PC, in-flight tracking and buffer bookkeeping; redirect overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= PC_RESET;
         req_pc   <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (i_redirect) begin
         pc       <= redirect_target;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            pc       <= pc + 32'd4;
            req_pc   <= pc;
            inflight <= 1'b1;
         end else begin
            inflight <= 1'b0;
         end
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Buffer storage: a returned word is written at the tail with its PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_pc[i]    <= '0;
            entry_instr[i] <= '0;
         end
      end else if (push) begin
         entry_pc[wr_ptr]    <= req_pc;
         entry_instr[wr_ptr] <= i_mem_rdata;
      end
   end

   assign o_mem_addr  = pc;
   assign o_mem_valid = issue;
   assign o_instr_vld = (count != '0);
   assign o_instr     = entry_instr[rd_ptr];
   assign o_pc        = entry_pc[rd_ptr];

   // Occupancy gating on issue guarantees a free slot for every reply.
   assert property (@(posedge clk) disable iff (!rst_n) push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a ROM model answers accepted reads one cycle later,
// a reference model predicts the fetch address stream and issue decisions,
// and a monitor pops the expected {pc, word} queue on every decode handshake.
module tb_instr_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] PC_RESET = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] o_mem_addr;
   logic        o_mem_valid;
   logic        i_mem_ready = 1'b0;
   logic [31:0] i_mem_rdata = '0;
   logic        i_rdata_vld = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_instr_vld;
   logic        i_id_ready = 1'b0;

   instr_fetch #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .o_mem_addr   (o_mem_addr),
      .o_mem_valid  (o_mem_valid),
      .i_mem_ready  (i_mem_ready),
      .i_mem_rdata  (i_mem_rdata),
      .i_rdata_vld  (i_rdata_vld),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_instr_vld  (o_instr_vld),
      .i_id_ready   (i_id_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          t;
   } ent_t;

   ent_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] model_pc = PC_RESET;
   bit          accept = 1'b0;
   logic [31:0] resp_addr = '0;
   bit          spurious_en = 1'b0;
   int          n;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0013;
         32'h0000_0004: return 32'h0010_0093;
         32'h0000_0008: return 32'h0020_0113;
         default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: word becomes visible two cycles after its request was accepted;
   // every handshake must deliver the oldest expected {pc, word}.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("instr_vld", {31'd0, o_instr_vld},
             {31'd0, (q.size() > 0) && (q[0].t + 2 <= cyc)});
         if (o_instr_vld && i_id_ready && !i_redirect) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_empty: got pc %h expected no delivery (cycle %0d)", o_pc, cyc);
            end else begin
               chk("pop_pc", o_pc, q[0].pc);
               chk("pop_instr", o_instr, rom(q[0].pc));
               void'(q.pop_front());
            end
         end
      end
   end

   // One clock: check issue/address against the model, then play the ROM.
   task automatic cycle();
      bit exp_issue;
      @(negedge clk);
      #1;
      if (!rst_n) begin
         chk("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
         chk("rst_instr_vld", {31'd0, o_instr_vld}, 32'd0);
         chk("rst_mem_addr", o_mem_addr, PC_RESET);
         accept = 1'b0;
      end else begin
         exp_issue = i_mem_ready && !i_redirect && (q.size() < DEPTH);
         chk("mem_valid", {31'd0, o_mem_valid}, {31'd0, exp_issue});
         chk("mem_addr", o_mem_addr, model_pc);
         accept    = o_mem_valid && i_mem_ready;
         resp_addr = o_mem_addr;
         if (i_redirect) begin
            q.delete();
            model_pc = {i_redirect_pc[31:2], 2'b00};
         end else if (exp_issue) begin
            q.push_back('{pc: model_pc, t: cyc});
            model_pc = model_pc + 32'd4;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (accept) begin
         i_rdata_vld = 1'b1;
         i_mem_rdata = rom(resp_addr);
      end else begin
         i_rdata_vld = spurious_en && ($urandom_range(0, 4) == 0);
         i_mem_rdata = $urandom;
      end
   endtask

   task automatic release_reset();
      rst_n       = 1'b1;
      cyc         = 0;
      i_mem_ready = 1'b0;
   endtask

   initial begin
      // Power-on reset; outputs must be in their reset state.
      #1 rst_n = 1'b0;
      repeat (3) cycle();
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_pc", o_pc, 32'd0);

      // Release; ROM raises ready one cycle later, decode always ready.
      release_reset();
      i_id_ready = 1'b1;
      cycle();
      i_mem_ready = 1'b1;
      cycle();
      chk("first_vld_early", {31'd0, o_instr_vld}, 32'd0);
      cycle();
      chk("first_vld_c3", {31'd0, o_instr_vld}, 32'd1);
      chk("first_pc", o_pc, 32'h0000_0000);
      chk("first_instr", o_instr, 32'h0000_0013);
      repeat (3) cycle();

      // Decode stall for 5 cycles: buffer fills, issue stops.
      i_id_ready = 1'b0;
      repeat (5) cycle();
      chk("stall_no_issue", {31'd0, o_mem_valid}, 32'd0);
      chk("stall_vld", {31'd0, o_instr_vld}, 32'd1);

      // One pop with ROM busy, then one fetch so one word is in flight.
      i_id_ready  = 1'b1;
      i_mem_ready = 1'b0;
      cycle();
      i_id_ready  = 1'b0;
      i_mem_ready = 1'b1;
      cycle();
      // Redirect together with decode ready and returning data.
      chk("redir_rdata_vld", {31'd0, i_rdata_vld}, 32'd1);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0042;
      i_id_ready    = 1'b1;
      cycle();
      i_redirect = 1'b0;
      chk("redir_flush_vld", {31'd0, o_instr_vld}, 32'd0);
      n = 0;
      while (!o_instr_vld && n < 10) begin
         cycle();
         n++;
      end
      chk("redir_latency", n, 32'd2);
      chk("redir_pc", o_pc, 32'h0000_0040);
      repeat (4) cycle();

      // PC wrap at the top of the address space (low bits masked).
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFFE;
      cycle();
      i_redirect = 1'b0;
      chk("wrap_top_addr", o_mem_addr, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_zero_addr", o_mem_addr, 32'h0000_0000);
      repeat (6) cycle();

      // Fill the buffer, then reset asynchronously mid-cycle.
      i_id_ready = 1'b0;
      repeat (4) cycle();
      chk("full_before_rst", {31'd0, o_instr_vld}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_instr_vld", {31'd0, o_instr_vld}, 32'd0);
      chk("async_mem_valid", {31'd0, o_mem_valid}, 32'd0);
      chk("async_mem_addr", o_mem_addr, PC_RESET);
      chk("async_instr", o_instr, 32'd0);
      chk("async_pc", o_pc, 32'd0);
      q.delete();
      model_pc    = PC_RESET;
      i_rdata_vld = 1'b0;
      repeat (2) cycle();
      release_reset();
      i_id_ready = 1'b1;
      cycle();

      // Randomized traffic with redirects and stray rdata_vld pulses.
      spurious_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         i_mem_ready = ($urandom_range(0, 3) != 0);
         i_id_ready  = ($urandom_range(0, 9) < 7);
         i_redirect  = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 3) == 0)
            i_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            i_redirect_pc = $urandom;
         cycle();
      end

      // Drain.
      i_redirect  = 1'b0;
      i_mem_ready = 1'b0;
      i_id_ready  = 1'b1;
      spurious_en = 1'b0;
      repeat (6) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
